// File: rtl/and_share_pkg.sv
// Shared types, defaults and helpers for the shared AND-datapath arbiter.
package and_share_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } state_e;

  localparam int unsigned DefNumReq = 4;
  localparam int unsigned DefWidth  = 4;
  localparam int unsigned DefCntW   = 16;

  // Requester-ID width; a single requester still needs one ID bit.
  function automatic int unsigned id_w(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/and_share_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the consumer.
interface and_share_arbiter_if
  import and_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned CNT_W   = DefCntW
);
  localparam int unsigned ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic [CNT_W-1:0]         op_count;

  // Requester/consumer side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, op_count
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, op_count
  );

endinterface

// File: rtl/and_share_arbiter_and_unit.sv
// Combinational bitwise-AND datapath shared by all requesters.
module and_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = a_i & b_i;

endmodule

// File: rtl/and_share_arbiter.sv
// Round-robin arbiter sharing one AND unit; registered result on a valid/ready port.
module and_share_arbiter
  import and_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned CNT_W   = DefCntW
) (
  input logic                clk,
  input logic                rst,
  and_share_arbiter_if.slave bus
);

  localparam int unsigned ID_W = id_w(NUM_REQ);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]   data_q;
  logic [ID_W-1:0]    id_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] req_ready;
  logic               can_accept;
  logic               accept;
  logic [WIDTH-1:0]   a_sel, b_sel, and_y;

  // Round-robin search starting at ptr_q; first valid requester wins.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx -= NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

  // Handshake qualification; a held, unconsumed result blocks new grants.
  always_comb begin
    can_accept = (state_q == StIdle) || bus.rsp_ready;
    req_ready  = (can_accept && !rst) ? grant : '0;
    accept     = |(bus.req_valid & req_ready);
    ptr_d      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  assign a_sel = bus.req_a[grant_idx*WIDTH +: WIDTH];
  assign b_sel = bus.req_b[grant_idx*WIDTH +: WIDTH];

  and_unit #(
    .WIDTH (WIDTH)
  ) u_and_unit (
    .a_i (a_sel),
    .b_i (b_sel),
    .y_o (and_y)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state: a new accept always (re)loads the hold slot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StHold;
      StHold:  if (!accept && bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.rsp_valid = (state_q == StHold);
    bus.req_ready = req_ready;
  end

  // Result, pointer and counter registers; all update only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      id_q   <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      data_q <= and_y;
      id_q   <= grant_idx;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.rsp_data = data_q;
  assign bus.rsp_id   = id_q;
  assign bus.op_count = cnt_q;

endmodule

// File: tb/tb_and_share_arbiter.sv
// Directed self-checking bench for and_share_arbiter (4 requesters, 4-bit, 4-bit counter).
module tb_and_share_arbiter;
  import and_share_pkg::*;

  localparam int unsigned NumReq = 4;
  localparam int unsigned Width  = 4;
  localparam int unsigned CntW   = 4;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  and_share_arbiter_if #(
    .NUM_REQ (NumReq),
    .WIDTH   (Width),
    .CNT_W   (CntW)
  ) bus ();

  and_share_arbiter #(
    .NUM_REQ (NumReq),
    .WIDTH   (Width),
    .CNT_W   (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [3:0] d,
                           input logic [1:0] id, input logic [3:0] cnt);
    check_eq({tag, ".valid"}, 32'(bus.rsp_valid), 32'(v));
    check_eq({tag, ".data"},  32'(bus.rsp_data),  32'(d));
    check_eq({tag, ".id"},    32'(bus.rsp_id),    32'(id));
    check_eq({tag, ".count"}, 32'(bus.op_count),  32'(cnt));
  endtask

  initial begin
    logic [1:0] ids2 [5];
    logic [3:0] dat2 [5];
    logic [3:0] a6, b6;

    // Reset with requests pending: no grant while rst is high.
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1 check_eq("reset.req_ready", 32'(bus.req_ready), 32'h0);
    step();
    check_rsp("reset", 1'b0, 4'h0, 2'd0, 4'd0);

    // 1: single request from requester 0.
    rst           = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_a     = 16'h000A;
    bus.req_b     = 16'h000F;
    #1 check_eq("t1.req_ready", 32'(bus.req_ready), 32'h1);
    step();
    check_rsp("t1", 1'b1, 4'b1010, 2'd0, 4'd1);
    bus.req_valid = 4'b0000;
    step();
    check_eq("t1.drain.valid", 32'(bus.rsp_valid), 32'h0);

    // 2: all requesting from ptr=0 -> ids 0,1,2,3,0 back to back.
    rst = 1'b1;
    step();
    rst           = 1'b0;
    bus.req_a     = 16'hFC63;   // a3..a0 = F,C,6,3
    bus.req_b     = 16'h5AFF;   // b3..b0 = 5,A,F,F -> results 5,8,6,3
    bus.req_valid = 4'hF;
    ids2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    dat2 = '{4'h3, 4'h6, 4'h8, 4'h5, 4'h3};
    for (int k = 0; k < 5; k++) begin
      step();
      check_rsp($sformatf("t2.%0d", k), 1'b1, dat2[k], ids2[k], 4'(k + 1));
    end

    // 5: reset while holding a result with op_count=5.
    rst = 1'b1;
    #1 check_eq("t5.rst.req_ready", 32'(bus.req_ready), 32'h0);
    step();
    rst = 1'b0;
    check_rsp("t5.after_rst", 1'b0, 4'h0, 2'd0, 4'd0);
    bus.req_valid = 4'b1001;
    #1 check_eq("t5.req_ready", 32'(bus.req_ready), 32'b0001);
    step();
    check_rsp("t5.grant", 1'b1, 4'h3, 2'd0, 4'd1);

    // 3: back-pressure holds result and blocks grants for 3 cycles.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1 check_eq($sformatf("t3.stall%0d.req_ready", k), 32'(bus.req_ready), 32'h0);
      step();
      check_rsp($sformatf("t3.stall%0d", k), 1'b1, 4'h3, 2'd0, 4'd1);
    end
    bus.rsp_ready = 1'b1;
    #1 check_eq("t3.release.req_ready", 32'(bus.req_ready), 32'b0010);
    step();
    check_rsp("t3.release", 1'b1, 4'h6, 2'd1, 4'd2);

    // 4: last grant 2, then 1010 -> requester 3 first, then 1.
    bus.req_valid = 4'b0100;
    #1 check_eq("t4.g2.req_ready", 32'(bus.req_ready), 32'b0100);
    step();
    check_rsp("t4.g2", 1'b1, 4'h8, 2'd2, 4'd3);
    bus.req_valid = 4'b1010;
    #1 check_eq("t4.g3.req_ready", 32'(bus.req_ready), 32'b1000);
    step();
    check_rsp("t4.g3", 1'b1, 4'h5, 2'd3, 4'd4);
    #1 check_eq("t4.g1.req_ready", 32'(bus.req_ready), 32'b0010);
    step();
    check_rsp("t4.g1", 1'b1, 4'h6, 2'd1, 4'd5);
    bus.req_valid = 4'b0000;
    step();
    check_eq("t4.drain.valid", 32'(bus.rsp_valid), 32'h0);
    check_eq("t4.drain.count", 32'(bus.op_count), 32'd5);

    // 6: 16 accepts with varying operands; counter wraps 15 -> 0.
    rst = 1'b1;
    step();
    rst           = 1'b0;
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      a6 = 4'((k * 7 + 3) % 16);
      b6 = ~4'(k);
      bus.req_a = {12'h000, a6};
      bus.req_b = {12'h000, b6};
      step();
      check_rsp($sformatf("t6.%0d", k), 1'b1, a6 & b6, 2'd0, 4'((k + 1) % 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
